// File: rtl/debounce_pkg.sv
// -----------------------------------------------------------------------------
// debounce_pkg
// Shared definitions for the sync_debounce glitch filter.
//   debounce_state_t      : FSM state encoding (IDLE_LOW is the reset state)
//   DEFAULT_STABLE_CYCLES : default qualification length in clocks
// -----------------------------------------------------------------------------
package debounce_pkg;

   typedef enum logic [1:0] {
      IDLE_LOW   = 2'd0,
      CHECK_HIGH = 2'd1,
      IDLE_HIGH  = 2'd2,
      CHECK_LOW  = 2'd3
   } debounce_state_t;

   localparam int unsigned DEFAULT_STABLE_CYCLES = 4;

endpackage

// File: rtl/sync_debounce.sv
// -----------------------------------------------------------------------------
// sync_debounce
// Glitch filter for the single-bit level coming out of the upstream delay
// stage. A new level is accepted only after it has been seen for
// STABLE_CYCLES consecutive clocks; accepted transitions are reported as
// one-cycle rise/fall pulses.
//
// Parameters:
//   STABLE_CYCLES  : consecutive cycles a new level must hold (2..255)
//   EDGE_CNT_WIDTH : width of the accepted-edge counter
//
// Ports:
//   i_clk        in   clock, rising edge
//   i_rst_n      in   synchronous active-low reset
//   i_d          in   raw level
//   o_d          out  debounced level
//   o_rise       out  one-cycle pulse on accepted 0->1
//   o_fall       out  one-cycle pulse on accepted 1->0
//   o_busy       out  high while a new level is being qualified
//   o_edge_count out  wrapping accepted-edge count (only with the macro)
//
// Configuration macro: SYNC_DEBOUNCE_EDGE_COUNT_EN adds o_edge_count and its
// counter register; without it the port and register do not exist.
// -----------------------------------------------------------------------------
import debounce_pkg::*;

module sync_debounce #(
   parameter int unsigned STABLE_CYCLES  = debounce_pkg::DEFAULT_STABLE_CYCLES,
   parameter int unsigned EDGE_CNT_WIDTH = 8
) (
   input  logic i_clk,
   input  logic i_rst_n,
   input  logic i_d,
   output logic o_d,
   output logic o_rise,
   output logic o_fall,
   output logic o_busy
`ifdef SYNC_DEBOUNCE_EDGE_COUNT_EN
   ,
   output logic [EDGE_CNT_WIDTH-1:0] o_edge_count
`endif
);

   localparam int unsigned CNT_W = $clog2(STABLE_CYCLES + 1);
   localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(STABLE_CYCLES - 1);

   // Reject illegal configurations at elaboration time.
   if ((STABLE_CYCLES < 2) || (STABLE_CYCLES > 255) || (EDGE_CNT_WIDTH < 1)) begin : g_param_check
      $error("sync_debounce: illegal STABLE_CYCLES or EDGE_CNT_WIDTH");
   end

   logic                   d_q;
   debounce_state_t        state_q;
   debounce_state_t        state_nxt;
   logic [CNT_W-1:0]       cnt_q;
   logic [CNT_W-1:0]       cnt_nxt;
   logic                   d_nxt;
   logic                   rise_nxt;
   logic                   fall_nxt;
   logic                   busy_nxt;

   // ---- Input register: every decision below looks at d_q, not i_d ----
   always_ff @(posedge i_clk) begin
      if (!i_rst_n) begin
         d_q <= 1'b0;
      end else begin
         d_q <= i_d;
      end
   end

   // ---- Next-state / output decode ----
   // cnt counts consecutive samples of the candidate level; the sample that
   // moves IDLE->CHECK is the first, so acceptance happens on the sample
   // where cnt already holds STABLE_CYCLES-1.
   always_comb begin
      state_nxt = state_q;
      cnt_nxt   = cnt_q;
      d_nxt     = o_d;
      rise_nxt  = 1'b0;
      fall_nxt  = 1'b0;
      case (state_q)
         IDLE_LOW: begin
            if (d_q) begin
               state_nxt = CHECK_HIGH;
               cnt_nxt   = CNT_ONE;
            end else begin
               cnt_nxt   = '0;
            end
         end
         CHECK_HIGH: begin
            if (!d_q) begin
               state_nxt = IDLE_LOW;
               cnt_nxt   = '0;
            end else if (cnt_q == CNT_LAST) begin
               state_nxt = IDLE_HIGH;
               d_nxt     = 1'b1;
               rise_nxt  = 1'b1;
               cnt_nxt   = '0;
            end else begin
               cnt_nxt   = cnt_q + CNT_ONE;
            end
         end
         IDLE_HIGH: begin
            if (!d_q) begin
               state_nxt = CHECK_LOW;
               cnt_nxt   = CNT_ONE;
            end else begin
               cnt_nxt   = '0;
            end
         end
         CHECK_LOW: begin
            if (d_q) begin
               state_nxt = IDLE_HIGH;
               cnt_nxt   = '0;
            end else if (cnt_q == CNT_LAST) begin
               state_nxt = IDLE_LOW;
               d_nxt     = 1'b0;
               fall_nxt  = 1'b1;
               cnt_nxt   = '0;
            end else begin
               cnt_nxt   = cnt_q + CNT_ONE;
            end
         end
         default: begin
            state_nxt = IDLE_LOW;
            cnt_nxt   = '0;
         end
      endcase
      // Busy is registered alongside the state so it lines up with it exactly.
      busy_nxt = (state_nxt == CHECK_HIGH) || (state_nxt == CHECK_LOW);
   end

   // ---- State and output registers ----
   always_ff @(posedge i_clk) begin
      if (!i_rst_n) begin
         state_q <= IDLE_LOW;
         cnt_q   <= '0;
         o_d     <= 1'b0;
         o_rise  <= 1'b0;
         o_fall  <= 1'b0;
         o_busy  <= 1'b0;
      end else begin
         state_q <= state_nxt;
         cnt_q   <= cnt_nxt;
         o_d     <= d_nxt;
         o_rise  <= rise_nxt;
         o_fall  <= fall_nxt;
         o_busy  <= busy_nxt;
      end
   end

`ifdef SYNC_DEBOUNCE_EDGE_COUNT_EN
   logic [EDGE_CNT_WIDTH-1:0] edge_cnt_q;

   // ---- Edge counter: steps after each cycle a pulse is visible, wraps ----
   always_ff @(posedge i_clk) begin
      if (!i_rst_n) begin
         edge_cnt_q <= '0;
      end else if (o_rise || o_fall) begin
         edge_cnt_q <= edge_cnt_q + 1'b1;
      end
   end

   assign o_edge_count = edge_cnt_q;
`endif

endmodule
